pid_velocity_sat: RTL and testbench
===================================

Name: pid_velocity_sat

Overview:
- Parametrised velocity-form (incremental) PID controller for the motor velocity loop; successor to the fixed 16-bit PID block.
- Time-multiplexes one registered multiplier over three precomputed coefficients.
- Adds a valid/ready sample handshake, coefficient-load and history-clear commands, error and output saturation, and fixed-point rounding.
- Sits between the velocity-measurement/setpoint logic and the PWM/step generator.

Parameters:
W, 16, signed width of sp, pv, gains and output
FRAC, 8, fractional bits of gains (gain 1.0 = 2^FRAC); FRAC >= 1
U_MAX, 32767, upper output clamp, signed W-bit
U_MIN, -32768, lower output clamp, signed W-bit; U_MIN < U_MAX

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_sp  in  W  setpoint, signed
i_pv  in  W  process value, signed
i_kp, i_ki, i_kd  in  W each  gains, signed Q(W-FRAC).FRAC
i_k_load  in  1  latch gains and recompute coefficients
i_clr  in  1  clear error history and output
i_valid  in  1  sample request
o_ready  out  1  high only in IDLE
o_un  out  W  controller output, signed
o_valid  out  1  one-cycle pulse when o_un updates
o_sat_hi  out  1  last output clamped to U_MAX
o_sat_lo  out  1  last output clamped to U_MIN
o_err_sat  out  1  last error clamped to W bits

Behaviour:
- Reset: state IDLE; o_un, e1, e2, K0, K1, K2, accumulator = 0; o_valid, o_sat_hi, o_sat_lo, o_err_sat = 0; o_ready = 1 after reset release.
- Reset mid-operation aborts the sample. No o_valid is produced for it.
- Coefficients are signed W+2 bits:
  - K0 = kp + ki + kd
  - K1 = -(kp + 2*kd)
  - K2 = kd
- Update law:
  - du = K0*e + K1*e1 + K2*e2, in a 2W+4-bit accumulator
  - du is rounded by adding 2^(FRAC-1), then arithmetic-shifted right by FRAC
  - u_new = clamp(o_un + du, U_MIN, U_MAX), computed at full width before the clamp
- Error: e = sp - pv in W+1 bits, clamped to the signed W range. o_err_sat is set if a clamp occurred.
- IDLE command priority, evaluated at the clock edge; lower-priority commands that coincide are dropped:
  1. i_clr: e1, e2, o_un = 0; flags cleared; stays IDLE; o_ready stays high.
  2. i_k_load: COEF for 1 cycle (o_ready low), then IDLE.
  3. i_valid: accept the sample; go to ERR.
- Datapath sequence, one cycle each:
  - ERR: register e.
  - M0: issue K0*e.
  - M1: issue K1*e1; acc = P0.
  - M2: issue K2*e2; acc += P1.
  - ACC: acc += P2.
  - OUT: register o_un = u_new and the sat flags; e2 <= e1; e1 <= e; then IDLE.
- Multiplier has a 1-cycle registered latency.
- Handshake timing:
  - Accept edge N → o_valid high for exactly 1 cycle following edge N+6, coincident with o_ready returning high.
  - Back-to-back accepts give 1 sample per 7 cycles.
  - i_valid, i_k_load and i_clr are ignored outside IDLE.
  - sp and pv are captured only at the accept edge.
- Clamp flags and o_un hold their value between o_valid pulses.
- Gains are sampled only at the COEF edge. Gain changes without i_k_load have no effect.
- Unreachable state encodings return to IDLE.

Test Plan:
- Proportional (W=16, FRAC=8): load kp=256, ki=kd=0; two samples sp=100, pv=0 → o_un=100 then 100. Latency is 6 edges; o_ready is low 6 cycles per sample.
- Integral: ki=256, kp=kd=0; three samples sp=10, pv=0 → o_un=10, 20, 30. Then i_clr → o_un=0.
- Derivative: kd=256 only; three samples e=100 → o_un=100, 0, 0.
- Saturation / anti-windup (U_MAX=1000): ki=256, sp=600, pv=0 → 600, then 1000 with o_sat_hi=1. Next sample pv=700 (e=-100) → 900 with o_sat_hi=0.
- Error clamp and rounding: sp=32767, pv=-32768, kp=1 → e=32767 and o_err_sat=1; du = round(32767/256) = 128 → o_un=128.
- Handshake / reset:
  - i_valid held high continuously → exactly one o_valid per 7 cycles.
  - i_clr and i_valid together → clear only, no o_valid.
  - i_rst asserted in M1 → all outputs 0 immediately, no o_valid; the next sample behaves as the first after reset.

Source files
------------

// File: rtl/pid_velocity_sat.sv
// Velocity-form (incremental) PID controller with saturation.
// One registered multiplier is shared across the three precomputed
// coefficients. Each accepted sample takes 7 cycles: accept, ERR, M0, M1,
// M2, ACC, OUT. Both the error and the output are clamped, and each clamp
// is reported on its own flag.
module pid_velocity_sat #(
    parameter int W     = 16,
    parameter int FRAC  = 8,
    parameter int U_MAX = 32767,
    parameter int U_MIN = -32768
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_sp,
    input  logic [W-1:0] i_pv,
    input  logic [W-1:0] i_kp,
    input  logic [W-1:0] i_ki,
    input  logic [W-1:0] i_kd,
    input  logic         i_k_load,
    input  logic         i_clr,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_un,
    output logic         o_valid,
    output logic         o_sat_hi,
    output logic         o_sat_lo,
    output logic         o_err_sat
);
    localparam int KW = W + 2;       // coefficient width
    localparam int PW = KW + W;      // product width
    localparam int AW = 2 * W + 4;   // accumulator width
    localparam int SW = AW + 1;      // rounding / output-sum width

    localparam logic signed [SW-1:0] UMAX_X = SW'(U_MAX);
    localparam logic signed [SW-1:0] UMIN_X = SW'(U_MIN);
    localparam logic signed [W-1:0]  UMAX_W = W'(U_MAX);
    localparam logic signed [W-1:0]  UMIN_W = W'(U_MIN);
    localparam logic signed [SW-1:0] HALF   = SW'(longint'(1) <<< (FRAC - 1));

    typedef enum logic [2:0] {IDLE, COEF, ERR, M0, M1, M2, ACC, OUT} state_t;

    state_t state_q, state_d;
    logic signed [W-1:0]  sp_q, sp_d, pv_q, pv_d;
    logic signed [W-1:0]  e_q, e_d, e1_q, e1_d, e2_q, e2_d, un_q, un_d;
    logic signed [KW-1:0] k0_q, k0_d, k1_q, k1_d, k2_q, k2_d;
    logic signed [PW-1:0] p_q, p_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic esat_q, esat_d, valid_q, valid_d;
    logic sathi_q, sathi_d, satlo_q, satlo_d, errsat_q, errsat_d;

    logic signed [W:0]    diff;
    logic signed [KW-1:0] kp_x, ki_x, kd_x, mul_a;
    logic signed [W-1:0]  mul_b;
    logic signed [SW-1:0] rnd, du, sum;

    // Datapath helpers: error, gain extension, multiplier operand mux, rounding and output sum
    always_comb begin
        diff  = {sp_q[W-1], sp_q} - {pv_q[W-1], pv_q};
        kp_x  = {{2{i_kp[W-1]}}, i_kp};
        ki_x  = {{2{i_ki[W-1]}}, i_ki};
        kd_x  = {{2{i_kd[W-1]}}, i_kd};
        mul_a = k0_q;
        mul_b = e_q;
        case (state_q)
            M1:      begin mul_a = k1_q; mul_b = e1_q; end
            M2:      begin mul_a = k2_q; mul_b = e2_q; end
            default: ;
        endcase
        p_d = {{W{mul_a[KW-1]}}, mul_a} * {{KW{mul_b[W-1]}}, mul_b};
        rnd = {acc_q[AW-1], acc_q} + HALF;
        du  = rnd >>> FRAC;
        sum = {{(SW-W){un_q[W-1]}}, un_q} + du;
    end

    // Next-state and register updates for the command decode and sequencing
    always_comb begin
        state_d  = state_q;
        sp_d     = sp_q;
        pv_d     = pv_q;
        e_d      = e_q;
        e1_d     = e1_q;
        e2_d     = e2_q;
        un_d     = un_q;
        k0_d     = k0_q;
        k1_d     = k1_q;
        k2_d     = k2_q;
        acc_d    = acc_q;
        esat_d   = esat_q;
        valid_d  = 1'b0;
        sathi_d  = sathi_q;
        satlo_d  = satlo_q;
        errsat_d = errsat_q;
        case (state_q)
            IDLE: begin
                if (i_clr) begin
                    e1_d     = '0;
                    e2_d     = '0;
                    un_d     = '0;
                    sathi_d  = 1'b0;
                    satlo_d  = 1'b0;
                    errsat_d = 1'b0;
                end else if (i_k_load) begin
                    state_d = COEF;
                end else if (i_valid) begin
                    sp_d    = i_sp;
                    pv_d    = i_pv;
                    state_d = ERR;
                end
            end
            COEF: begin
                k0_d    = kp_x + ki_x + kd_x;
                k1_d    = -(kp_x + (kd_x <<< 1));
                k2_d    = kd_x;
                state_d = IDLE;
            end
            ERR: begin
                if (diff[W] != diff[W-1]) begin
                    e_d    = diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                    esat_d = 1'b1;
                end else begin
                    e_d    = diff[W-1:0];
                    esat_d = 1'b0;
                end
                state_d = M0;
            end
            M0: state_d = M1;
            M1: begin
                acc_d   = {{(AW-PW){p_q[PW-1]}}, p_q};
                state_d = M2;
            end
            M2: begin
                acc_d   = acc_q + {{(AW-PW){p_q[PW-1]}}, p_q};
                state_d = ACC;
            end
            ACC: begin
                acc_d   = acc_q + {{(AW-PW){p_q[PW-1]}}, p_q};
                state_d = OUT;
            end
            OUT: begin
                sathi_d = 1'b0;
                satlo_d = 1'b0;
                if (sum > UMAX_X) begin
                    un_d    = UMAX_W;
                    sathi_d = 1'b1;
                end else if (sum < UMIN_X) begin
                    un_d    = UMIN_W;
                    satlo_d = 1'b1;
                end else begin
                    un_d = sum[W-1:0];
                end
                errsat_d = esat_q;
                e2_d     = e1_q;
                e1_d     = e_q;
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared by asynchronous reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            sp_q     <= '0;
            pv_q     <= '0;
            e_q      <= '0;
            e1_q     <= '0;
            e2_q     <= '0;
            un_q     <= '0;
            k0_q     <= '0;
            k1_q     <= '0;
            k2_q     <= '0;
            p_q      <= '0;
            acc_q    <= '0;
            esat_q   <= 1'b0;
            valid_q  <= 1'b0;
            sathi_q  <= 1'b0;
            satlo_q  <= 1'b0;
            errsat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            pv_q     <= pv_d;
            e_q      <= e_d;
            e1_q     <= e1_d;
            e2_q     <= e2_d;
            un_q     <= un_d;
            k0_q     <= k0_d;
            k1_q     <= k1_d;
            k2_q     <= k2_d;
            p_q      <= p_d;
            acc_q    <= acc_d;
            esat_q   <= esat_d;
            valid_q  <= valid_d;
            sathi_q  <= sathi_d;
            satlo_q  <= satlo_d;
            errsat_q <= errsat_d;
        end
    end

    assign o_ready   = (state_q == IDLE);
    assign o_un      = un_q;
    assign o_valid   = valid_q;
    assign o_sat_hi  = sathi_q;
    assign o_sat_lo  = satlo_q;
    assign o_err_sat = errsat_q;

endmodule

// File: tb/tb_pid_velocity_sat.sv
// Directed bench for pid_velocity_sat (W=16, FRAC=8, outputs clamped to +/-1000).
module tb_pid_velocity_sat;
    logic        clk = 1'b0;
    logic        i_rst, i_k_load, i_clr, i_valid;
    logic [15:0] i_sp, i_pv, i_kp, i_ki, i_kd;
    logic        o_ready, o_valid, o_sat_hi, o_sat_lo, o_err_sat;
    logic [15:0] o_un;

    int tests = 0;
    int fails = 0;

    pid_velocity_sat #(.W(16), .FRAC(8), .U_MAX(1000), .U_MIN(-1000)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_sp(i_sp), .i_pv(i_pv),
        .i_kp(i_kp), .i_ki(i_ki), .i_kd(i_kd),
        .i_k_load(i_k_load), .i_clr(i_clr), .i_valid(i_valid),
        .o_ready(o_ready), .o_un(o_un), .o_valid(o_valid),
        .o_sat_hi(o_sat_hi), .o_sat_lo(o_sat_lo), .o_err_sat(o_err_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint un_s();
        return longint'($signed(o_un));
    endfunction

    task automatic load(input int kp, input int ki, input int kd);
        @(negedge clk);
        i_kp = 16'(kp); i_ki = 16'(ki); i_kd = 16'(kd); i_k_load = 1'b1;
        @(posedge clk); #1;
        i_k_load = 1'b0;
        check("coef_ready_low", longint'(o_ready), 0);
        @(posedge clk); #1;
        check("coef_ready_back", longint'(o_ready), 1);
    endtask

    task automatic clear();
        @(negedge clk);
        i_clr = 1'b1;
        @(posedge clk); #1;
        i_clr = 1'b0;
    endtask

    task automatic sample(input string tag, input int sp, input int pv, input longint exp_un);
        int lat;
        int lowc;
        @(negedge clk);
        i_sp = 16'(sp); i_pv = 16'(pv); i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat  = 0;
        lowc = (o_ready == 1'b0) ? 1 : 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (o_valid) lat = c;
            else if (!o_ready) lowc++;
        end
        check({tag, "_latency"}, longint'(lat), 6);
        check({tag, "_ready_low"}, longint'(lowc), 6);
        check({tag, "_un"}, un_s(), exp_un);
        @(posedge clk); #1;
        check({tag, "_valid_pulse"}, longint'(o_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int cnt;
        int last;
        i_rst = 1'b1; i_k_load = 1'b0; i_clr = 1'b0; i_valid = 1'b0;
        i_sp = '0; i_pv = '0; i_kp = '0; i_ki = '0; i_kd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        #1;
        check("rst_un", un_s(), 0);
        check("rst_valid", longint'(o_valid), 0);
        check("rst_sat_hi", longint'(o_sat_hi), 0);
        check("rst_sat_lo", longint'(o_sat_lo), 0);
        check("rst_err_sat", longint'(o_err_sat), 0);
        check("rst_ready", longint'(o_ready), 1);

        // Proportional
        load(256, 0, 0);
        sample("p1", 100, 0, 100);
        sample("p2", 100, 0, 100);

        // Integral, then clear
        clear();
        load(0, 256, 0);
        sample("i1", 10, 0, 10);
        sample("i2", 10, 0, 20);
        sample("i3", 10, 0, 30);
        clear();
        check("clr_un", un_s(), 0);

        // Derivative
        load(0, 0, 256);
        sample("d1", 100, 0, 100);
        sample("d2", 100, 0, 0);
        sample("d3", 100, 0, 0);

        // Upper saturation and recovery
        clear();
        load(0, 256, 0);
        sample("s1", 600, 0, 600);
        check("s1_sat_hi", longint'(o_sat_hi), 0);
        sample("s2", 600, 0, 1000);
        check("s2_sat_hi", longint'(o_sat_hi), 1);
        sample("s3", 600, 700, 900);
        check("s3_sat_hi", longint'(o_sat_hi), 0);

        // Lower saturation, flag and output hold while idle
        clear();
        sample("l1", 0, 600, -600);
        sample("l2", 0, 600, -1000);
        check("l2_sat_lo", longint'(o_sat_lo), 1);
        check("l2_sat_hi", longint'(o_sat_hi), 0);
        repeat (5) @(posedge clk);
        #1;
        check("hold_sat_lo", longint'(o_sat_lo), 1);
        check("hold_un", un_s(), -1000);

        // Error clamp and rounding
        clear();
        load(1, 0, 0);
        sample("ec1", 32767, -32768, 128);
        check("ec1_err_sat", longint'(o_err_sat), 1);
        sample("ec2", 1, 0, 0);
        check("ec2_err_sat", longint'(o_err_sat), 0);

        // Gain change without load has no effect (K0 stays 1)
        clear();
        @(negedge clk);
        i_kp = 16'd256;
        sample("noload", 256, 0, 1);

        // clr and valid together: clear wins, no sample
        @(negedge clk);
        i_clr = 1'b1; i_valid = 1'b1; i_sp = 16'd5; i_pv = '0;
        @(posedge clk); #1;
        i_clr = 1'b0; i_valid = 1'b0;
        check("clrvalid_ready", longint'(o_ready), 1);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (o_valid) cnt++;
        end
        check("clrvalid_no_valid", longint'(cnt), 0);
        check("clrvalid_un", un_s(), 0);

        // Continuous valid: one result every 7 cycles
        load(0, 256, 0);
        @(negedge clk);
        i_sp = 16'd1; i_pv = '0; i_valid = 1'b1;
        cnt  = 0;
        last = -1;
        for (int k = 0; k < 35; k++) begin
            @(posedge clk); #1;
            if (o_valid) begin
                if (last >= 0) check("stream_gap", longint'(k - last), 7);
                else check("stream_first", longint'(k), 6);
                last = k;
                cnt++;
            end
        end
        i_valid = 1'b0;
        check("stream_count", longint'(cnt), 5);
        check("stream_un", un_s(), 5);

        // Reset during M1 aborts the sample
        load(256, 0, 0);
        @(negedge clk);
        i_sp = 16'd50; i_pv = '0; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("m1_ready_low", longint'(o_ready), 0);
        i_rst = 1'b1;
        #1;
        check("midrst_un", un_s(), 0);
        check("midrst_valid", longint'(o_valid), 0);
        check("midrst_sat_hi", longint'(o_sat_hi), 0);
        check("midrst_err_sat", longint'(o_err_sat), 0);
        cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (o_valid) cnt++;
        end
        check("midrst_no_valid", longint'(cnt), 0);
        load(256, 0, 0);
        sample("after_rst", 50, 0, 50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
